// File: rtl/inst_fetch_buffer.sv
// inst_fetch_buffer: prefetch FIFO of {pc+4, inst} pairs between a multi-cycle imem and IF/ID.
// Define FETCH_BUF_BYPASS_EN to forward an ack straight to the outputs when the FIFO is empty.
module inst_fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    output logic                     imem_req_o,
    output logic [31:0]              imem_addr_o,
    input  logic                     imem_ack_i,
    input  logic [31:0]              imem_data_i,
    output logic                     out_valid_o,
    output logic [31:0]              out_pc4_o,
    output logic [31:0]              out_inst_o,
    input  logic                     out_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t         state_q, state_d;
    logic [31:0]    fpc_q, fpc_d, addr_q, addr_d, fpc_inc;
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic [31:0]    mem_pc4 [DEPTH];
    logic [31:0]    mem_inst [DEPTH];
    logic           ack_req, bypass, push, pop, fifo_valid;

    assign fpc_inc    = fpc_q + 32'd4;
    assign ack_req    = (state_q == REQ) && imem_ack_i;
    assign fifo_valid = count_q != '0;
`ifdef FETCH_BUF_BYPASS_EN
    assign bypass = ack_req && !redirect_i && !fifo_valid;
`else
    assign bypass = 1'b0;
`endif
    // A bypassed word that is accepted immediately never occupies a slot.
    assign push    = ack_req && !redirect_i && !(bypass && out_ready_i);
    assign pop     = fifo_valid && out_ready_i && !redirect_i;
    assign count_d = redirect_i ? '0 : count_q + CW'(push) - CW'(pop);

    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        case (state_q)
            IDLE: begin
                if (redirect_i) fpc_d = redirect_pc_i;
                if (start_i && (redirect_i || count_q < CW'(DEPTH))) state_d = REQ;
            end
            REQ: begin
                if (redirect_i) begin
                    fpc_d   = redirect_pc_i;
                    state_d = !imem_ack_i ? DROP : start_i ? REQ : IDLE;
                end else if (imem_ack_i) begin
                    fpc_d   = fpc_inc;
                    state_d = (start_i && count_d < CW'(DEPTH)) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (redirect_i) fpc_d = redirect_pc_i;
                if (imem_ack_i) state_d = start_i ? REQ : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The address only moves when a fresh request starts; a stale one keeps its address.
    assign addr_d = (state_d == REQ && (state_q != REQ || imem_ack_i)) ? fpc_d : addr_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            fpc_q    <= RESET_PC;
            addr_q   <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            addr_q   <= addr_d;
            wr_ptr_q <= redirect_i ? '0 : wr_ptr_q + AW'(push);
            rd_ptr_q <= redirect_i ? '0 : rd_ptr_q + AW'(pop);
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_pc4[wr_ptr_q]  <= fpc_inc;
            mem_inst[wr_ptr_q] <= imem_data_i;
        end
    end

    assign imem_req_o  = state_q != IDLE;
    assign imem_addr_o = addr_q;
    assign count_o     = count_q;
    assign out_valid_o = fifo_valid || bypass;
    assign out_pc4_o   = fifo_valid ? mem_pc4[rd_ptr_q] : bypass ? fpc_inc : '0;
    assign out_inst_o  = fifo_valid ? mem_inst[rd_ptr_q] : bypass ? imem_data_i : '0;
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// tb_inst_fetch_buffer: directed vectors for the fetch buffer; memory returns addr^A5A5_0000.
module tb_inst_fetch_buffer;
    logic        clk = 1'b0, rst_n, start, redirect, ack, ready, req, valid;
    logic [31:0] redirect_pc, addr, data, pc4, inst;
    logic [2:0]  count;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;
    assign data = addr ^ 32'hA5A5_0000;

    inst_fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem_req_o(req), .imem_addr_o(addr),
        .imem_ack_i(ack), .imem_data_i(data), .out_valid_o(valid),
        .out_pc4_o(pc4), .out_inst_o(inst), .out_ready_i(ready), .count_o(count)
    );

    typedef struct {
        logic s, r; logic [31:0] rpc; logic a, rd;
        logic rq; logic [31:0] ad; logic v; logic [31:0] p, i; logic [2:0] c;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic rq, input logic [31:0] ad,
                              input logic v, input logic [31:0] p, input logic [31:0] i,
                              input logic [2:0] c);
        chk({tag, ".req"}, 32'(req), 32'(rq));
        chk({tag, ".addr"}, addr, ad);
        chk({tag, ".valid"}, 32'(valid), 32'(v));
        chk({tag, ".pc4"}, pc4, p);
        chk({tag, ".inst"}, inst, i);
        chk({tag, ".count"}, 32'(count), 32'(c));
    endtask

    task automatic drive(input logic s, input logic r, input logic [31:0] rpc,
                         input logic a, input logic rd);
        @(negedge clk);
        start = s; redirect = r; redirect_pc = rpc; ack = a; ready = rd;
        #1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; redirect = 1'b0; redirect_pc = '0; ack = 1'b0; ready = 1'b0;
        #1;
        expect_out(tag, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        tbl[0] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0, 3'd0};
        tbl[1] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'h0, 3'd0};
        tbl[2] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h04, 1'b1, 32'h04, 32'hA5A5_0000, 3'd1};
        tbl[3] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h08, 32'hA5A5_0004, 3'd1};
        tbl[4] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h0C, 32'hA5A5_0008, 3'd1};
        tbl[5] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h10, 32'hA5A5_000C, 3'd1};
        tbl[6] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b0, 32'h00, 32'h0, 3'd0};
        tbl[7] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h14, 32'hA5A5_0010, 3'd1};
        do_reset("reset0");
`ifndef FETCH_BUF_BYPASS_EN
        for (int k = 0; k < 8; k++) begin
            drive(tbl[k].s, tbl[k].r, tbl[k].rpc, tbl[k].a, tbl[k].rd);
            expect_out($sformatf("stream%0d", k), tbl[k].rq, tbl[k].ad, tbl[k].v,
                       tbl[k].p, tbl[k].i, tbl[k].c);
        end
        // Back-pressure: fill to DEPTH, hold, then drain in order and resume at 0x10.
        do_reset("reset1");
        drive(1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 1, 0);
            chk($sformatf("fill%0d.count", k), 32'(count), k);
            chk($sformatf("fill%0d.addr", k), addr, 4 * k);
        end
        for (int k = 0; k < 6; k++) begin
            drive(1, 0, 0, 0, 0);
            chk($sformatf("full%0d.req", k), 32'(req), 0);
            chk($sformatf("full%0d.count", k), 32'(count), 4);
        end
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 0, 1);
            chk($sformatf("drain%0d.pc4", k), pc4, 4 * (k + 1));
            chk($sformatf("drain%0d.inst", k), inst, 32'hA5A5_0000 ^ (4 * k));
            chk($sformatf("drain%0d.count", k), 32'(count), 4 - k);
        end
        chk("resume.addr", addr, 32'h10);
        drive(1, 0, 0, 1, 1);
        expect_out("resume0", 1, 32'h10, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1);
        expect_out("resume1", 1, 32'h14, 1, 32'h14, 32'hA5A5_0010, 1);
        // Redirect while waiting on a slow ack: stale word dropped.
        do_reset("reset2");
        drive(1, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 1);
        drive(1, 1, 32'h100, 0, 1);
        expect_out("drop0", 1, 32'h0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 1);
        expect_out("drop1", 1, 32'h0, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 1);
        expect_out("drop2", 1, 32'h100, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        expect_out("drop3", 1, 32'h104, 1, 32'h104, 32'hA5A5_0100, 1);
        // Redirect coinciding with ack and pop at count=2.
        do_reset("reset3");
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 1, 0);
        drive(1, 0, 0, 1, 0);
        drive(1, 1, 32'h200, 1, 1);
        expect_out("flush0", 1, 32'h8, 1, 32'h4, 32'hA5A5_0000, 2);
        drive(1, 0, 0, 1, 1);
        expect_out("flush1", 1, 32'h200, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1);
        expect_out("flush2", 1, 32'h204, 1, 32'h204, 32'hA5A5_0200, 1);
        // start_i dropped mid-request: word still delivered, no more requests.
        do_reset("reset4");
        drive(1, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        chk("stop0.req", 32'(req), 1);
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 0, 1);
        expect_out("stop1", 0, 32'h0, 1, 32'h4, 32'hA5A5_0000, 1);
        drive(0, 0, 0, 0, 1);
        expect_out("stop2", 0, 32'h0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1);
        chk("stop3.req", 32'(req), 0);
        drive(1, 0, 0, 0, 1);
        expect_out("stop4", 1, 32'h4, 0, 0, 0, 0);
        // Asynchronous reset in the middle of a request.
        rst_n = 1'b0;
        #1;
        expect_out("areset", 0, 32'h0, 0, 0, 0, 0);
        rst_n = 1'b1;
`else
        drive(1, 0, 0, 0, 1);
        drive(1, 0, 0, 1, 1);
        expect_out("bypass0", 1, 32'h0, 1, 32'h4, 32'hA5A5_0000, 0);
        drive(0, 0, 0, 0, 1);
        expect_out("bypass1", 1, 32'h4, 0, 0, 0, 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/inst_fetch_buffer.md
# inst_fetch_buffer

Instruction prefetch buffer between a multi-cycle instruction memory and the IF/ID pipeline register. It owns the fetch PC, issues one outstanding memory request at a time, and queues returned instructions in a DEPTH-entry FIFO as {PC+4, instruction} pairs. It presents the FIFO head to IF/ID through a valid/ready handshake, where ready is the hazard unit's IF/ID write enable. A branch or jump redirect flushes the buffer and discards any in-flight response.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, fetch PC after reset
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  fetch enable; no new request is issued while low
- redirect_i  in  1  branch/jump taken: flush and refetch
- redirect_pc_i  in  32  new fetch PC when redirect_i=1
- imem_req_o  out  1  memory request
- imem_addr_o  out  32  request address
- imem_ack_i  in  1  transfer complete; imem_data_i is valid this cycle
- imem_data_i  in  32  returned instruction word
- out_valid_o  out  1  head entry valid
- out_pc4_o  out  32  PC+4 of the head instruction
- out_inst_o  out  32  head instruction; 32'h0 (NOP) when out_valid_o=0
- out_ready_i  in  1  IF/ID accepts the head (IFIDWrite)
- count_o  out  $clog2(DEPTH)+1  occupied entries

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - REQ: request outstanding for fpc.
  - DROP: outstanding request is stale and its response will be discarded.
- IDLE→REQ when start_i=1 and count<DEPTH. imem_addr_o=fpc.
- REQ behaviour:
  - imem_req_o=1. The address is held stable until imem_ack_i.
  - On ack: push {fpc+4, imem_data_i} and set fpc←fpc+4.
  - After the ack, stay in REQ with the new fpc if start_i=1 and post-push count<DEPTH (a simultaneous pop counts). Otherwise go to IDLE.
- Pop when out_valid_o & out_ready_i. Simultaneous push and pop leaves count unchanged.
- Redirect (highest priority):
  - Clears the FIFO, drops any same-cycle push or pop, and sets fpc←redirect_pc_i.
  - REQ without a same-cycle ack → DROP.
  - REQ with a same-cycle ack → data discarded; go to REQ at the new PC if start_i=1, else IDLE.
  - IDLE → REQ at the new PC if start_i=1.
- DROP: imem_req_o stays high at the stale address. When ack arrives, discard the data, then go to REQ at fpc (or IDLE if start_i=0).
  - A redirect while in DROP updates fpc and stays in DROP.
- Full FIFO (count=DEPTH): no issue. Empty FIFO: out_valid_o=0.
- Pointers wrap modulo DEPTH. fpc addition wraps modulo 2^32.
- start_i low mid-request: the outstanding transfer completes and is pushed; no further issue.

## Timing
- Reset (asynchronous, rst_i=0) sets:
  - State IDLE, fpc=RESET_PC.
  - imem_req_o=0, imem_addr_o=RESET_PC.
  - count_o=0, out_valid_o=0, out_pc4_o=0, out_inst_o=0.
  - Pointers 0.
- Reset mid-transfer abandons the request; the memory must also be reset.
- First request: imem_req_o rises in the cycle after the first edge with start_i=1.
- Ack-to-out_valid_o latency: 1 cycle (registered FIFO), unless the bypass is enabled.
- Sustained throughput with single-cycle ack: one instruction per cycle.
- After redirect_i, out_valid_o=0 from the next cycle on, until a new-PC instruction returns.
- Outputs are registered except for the bypass path.

## Configuration
- FETCH_BUF_BYPASS_EN defined: when the FIFO is empty and an ack arrives in REQ without a redirect, imem_data_i and fpc+4 drive the outputs combinationally with out_valid_o=1 in the same cycle.
  - If out_ready_i=1, the entry is consumed and not written.
  - Zero-cycle fetch latency.
- Undefined: all outputs come from the FIFO storage; 1-cycle latency as above.

## Test plan
- Reset then start_i=1 with ack every cycle returning addr^32'hA5A5_0000 → out_pc4_o 4,8,12,… with matching instructions in order, one per cycle after the fill latency.
- out_ready_i=0 for 10 cycles with DEPTH=4 → count_o saturates at 4, imem_req_o deasserts. Release → 4 entries drain in order and fetch resumes at PC 0x10.
- Ack delayed 3 cycles, redirect_i=1 to 0x100 in the second wait cycle → the stale response is discarded and the next request address is 0x100. The first delivered entry has out_pc4_o=0x104.
- Redirect in the same cycle as an ack and a pop with count=2 → count_o=0 next cycle, no stale entry is ever delivered, and the request issues to the redirect PC.
- start_i deasserted while a request is outstanding → that instruction is delivered, then imem_req_o stays 0. Reasserting start_i resumes at the next sequential PC.
- With FETCH_BUF_BYPASS_EN, FIFO empty, ack with out_ready_i=1 → out_valid_o=1 in the ack cycle and count_o stays 0.
